multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Next-generation main control for the MIPS core: a multi-cycle FSM replacing the single-cycle opcode decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls each cycle.
- Waits on a memory ready handshake, resolves branches internally, traps illegal opcodes and counts retired instructions.

Parameters:
ALUOP_W, 6, alu_op width (>=6); 6-bit codes zero-extended
CNT_W, 32, retired-instruction counter width
TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters TRAP; 0: executes as NOP
ENABLE_SUBI, 1, 1: opcode 6'b011111 (subi) legal; 0: illegal

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH handshake
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
ir_write, pc_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, jal  out  1 each  datapath controls
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
alu_op  out  ALUOP_W  ALU operation code
instr_done  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  sticky illegal-opcode flag
retired_count  out  CNT_W  count of instr_done pulses
state  out  4  current state, for debug

Behaviour:
- Reset (async): state=IDLE, retired_count=0, illegal=0. All outputs 0 in IDLE. IDLE->FETCH on the next edge after reset deasserts.
- Unlisted outputs are 0 in every state. Outputs decode from the state register; ir_write, pc_write and instr_done also depend on mem_ready or zero as noted.
- Encoding: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXEC7 ALUWB8 IEXEC9 IWB10 BRANCH11 JUMP12 JAL13 JR14 TRAP15.
- FETCH: mem_read=1, alu_src_b=01, alu_op=ADD(000000).
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_b=11, alu_op=ADD. Next state by opcode:
  - 000000 with funct 001000 -> JR; 000000 otherwise -> EXEC.
  - 001000, 001100, 001101, 001010, 001111, subi -> IEXEC.
  - 100011, 100000, 100001, 101011, 101000, 101001 -> MEMADR.
  - 000100, 000101, 000001 -> BRANCH; 000010 -> JUMP; 000011 -> JAL.
  - Anything else -> TRAP, or FETCH with instr_done when TRAP_ON_ILLEGAL=0.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Loads -> MEMRD; stores -> MEMWR.
- MEMRD: iord=1, mem_read=1; waits for mem_ready, then MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done -> FETCH.
- MEMWR: iord=1, mem_write=1; waits for mem_ready; on mem_ready: instr_done -> FETCH.
- EXEC: alu_src_a=1, alu_op=000010 (R-type) -> ALUWB. ALUWB: reg_dst=1, reg_write=1, instr_done -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=opcode -> IWB. IWB: reg_write=1, instr_done -> FETCH.
- BRANCH: alu_src_a=1, pc_src=01, instr_done -> FETCH.
  - alu_op: BEQ 000001, BNE 000101, BEZ 111111.
  - pc_write = zero for BEQ/BEZ, ~zero for BNE.
- JUMP: pc_src=10, pc_write=1, instr_done. JAL: adds reg_write=1, jal=1. JR: pc_src=11, pc_write=1, instr_done. All -> FETCH.
- TRAP: illegal=1 (set on entry, held); all other outputs 0; leaves only via reset.
- retired_count increments on instr_done and wraps at 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction aborts it immediately; no partial pulse follows.

Test Plan:
- Reset then mem_ready=1 constant, opcode=000000, funct=100000 -> states 1,2,7,8,1; ALUWB reg_dst=1, reg_write=1; retired_count=1 after 4 cycles from FETCH.
- lw (100011), mem_ready held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles; MEMWB mem_to_reg=1; lw totals 8 cycles.
- BNE with zero=1 -> pc_write=0 in BRANCH. BEQ with zero=1 -> pc_write=1, pc_src=01. Both count as retired.
- opcode=000000, funct=001000 -> JR with pc_src=11, pc_write=1. JAL (000011) -> jal=1, reg_write=1, pc_src=10.
- opcode=111110, TRAP_ON_ILLEGAL=1 -> state 15, illegal=1 held 20 cycles, count frozen; reset -> IDLE, illegal=0, count=0.
- ENABLE_SUBI=0 with opcode 011111 -> TRAP. Reset asserted in MEMWR -> mem_write drops asynchronously, no instr_done.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the MIPS core: sequences fetch/decode/execute,
// drives datapath controls from the state register, traps illegal opcodes and counts retirements.
module multicycle_control #(
    parameter int ALUOP_W         = 6,
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int ENABLE_SUBI     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               jal,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired_count,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_IEXEC = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
        S_JUMP   = 4'd12, S_JAL   = 4'd13, S_JR     = 4'd14, S_TRAP   = 4'd15
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic [5:0]       w_alu_op6;
    logic             w_is_rtype, w_is_jr, w_is_imm, w_is_load, w_is_store;
    logic             w_is_branch, w_is_jump, w_is_jal, w_is_illegal;

    // Opcode classification; opcode is held stable by the datapath from DECODE onwards.
    always_comb begin
        w_is_jr      = (opcode == 6'b000000) && (funct == 6'b001000);
        w_is_rtype   = (opcode == 6'b000000) && (funct != 6'b001000);
        w_is_imm     = (opcode inside {6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111})
                       || ((ENABLE_SUBI != 0) && (opcode == 6'b011111));
        w_is_load    = opcode inside {6'b100011, 6'b100000, 6'b100001};
        w_is_store   = opcode inside {6'b101011, 6'b101000, 6'b101001};
        w_is_branch  = opcode inside {6'b000100, 6'b000101, 6'b000001};
        w_is_jump    = (opcode == 6'b000010);
        w_is_jal     = (opcode == 6'b000011);
        w_is_illegal = !(w_is_jr || w_is_rtype || w_is_imm || w_is_load || w_is_store
                         || w_is_branch || w_is_jump || w_is_jal);
    end

    // State sequencing, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= {CNT_W{1'b0}};
            r_illegal <= 1'b0;
        end else begin
            if (instr_done) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (w_is_jr)                           r_state <= S_JR;
                    else if (w_is_rtype)                   r_state <= S_EXEC;
                    else if (w_is_imm)                     r_state <= S_IEXEC;
                    else if (w_is_load || w_is_store)      r_state <= S_MEMADR;
                    else if (w_is_branch)                  r_state <= S_BRANCH;
                    else if (w_is_jump)                    r_state <= S_JUMP;
                    else if (w_is_jal)                     r_state <= S_JAL;
                    else if (TRAP_ON_ILLEGAL != 0) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else                               r_state <= S_FETCH;
                end
                S_MEMADR: r_state <= w_is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:  r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   r_state <= S_ALUWB;
                S_IEXEC:  r_state <= S_IWB;
                S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                          r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        jal        = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        w_alu_op6  = 6'b000000;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                instr_done = w_is_illegal && (TRAP_ON_ILLEGAL == 0);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op6 = 6'b000010;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_alu_op6 = opcode;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                if (opcode == 6'b000101) begin
                    w_alu_op6 = 6'b000101;
                    pc_write  = ~zero;
                end else if (opcode == 6'b000100) begin
                    w_alu_op6 = 6'b000001;
                    pc_write  = zero;
                end else begin
                    w_alu_op6 = 6'b111111;
                    pc_write  = zero;
                end
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                jal        = 1'b1;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = 2'b11;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                instr_done = 1'b0;
            end
        endcase
    end

    assign alu_op        = ALUOP_W'(w_alu_op6);
    assign illegal       = r_illegal;
    assign retired_count = r_count;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle traces are
// generated from the instruction-class rules and compared cycle by cycle.
module tb_multicycle_control;

    localparam bit A_TRAP = 1'b1;
    localparam bit A_SUBI = 1'b1;

    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;

    logic        ir_write, pc_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, jal;
    logic [1:0]  alu_src_b, pc_src;
    logic [5:0]  alu_op;
    logic        instr_done, illegal;
    logic [31:0] retired_count;
    logic [3:0]  state;

    logic        ir_write_b, pc_write_b, iord_b, mem_read_b, mem_write_b, mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, jal_b;
    logic [1:0]  alu_src_b_b, pc_src_b;
    logic [5:0]  alu_op_b;
    logic        instr_done_b, illegal_b;
    logic [2:0]  retired_count_b;
    logic [3:0]  state_b;

    logic [20:0] w_obs;
    assign w_obs = {ir_write, pc_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                    alu_src_a, jal, alu_src_b, pc_src, alu_op, instr_done};

    typedef struct {
        logic [3:0]  st;
        logic [20:0] ctl;
        logic        mr;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam int C_R = 0, C_JR = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_J = 6, C_JAL = 7, C_ILL = 8;

    multicycle_control #(.ALUOP_W(6), .CNT_W(32), .TRAP_ON_ILLEGAL(1), .ENABLE_SUBI(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .jal(jal),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .retired_count(retired_count), .state(state)
    );

    multicycle_control #(.ALUOP_W(6), .CNT_W(3), .TRAP_ON_ILLEGAL(1), .ENABLE_SUBI(0)) dut_b (
        .clk(clk), .reset(reset_b), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write_b), .pc_write(pc_write_b), .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b), .alu_src_a(alu_src_a_b), .jal(jal_b),
        .alu_src_b(alu_src_b_b), .pc_src(pc_src_b), .alu_op(alu_op_b), .instr_done(instr_done_b), .illegal(illegal_b),
        .retired_count(retired_count_b), .state(state_b)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] ctl(logic [9:0] f, logic [1:0] asb, logic [1:0] pcs, logic [5:0] aop, logic done);
        return {f, asb, pcs, aop, done};
    endfunction

    function automatic void add(logic [3:0] st, logic [20:0] c, logic mr);
        cyc_t e;
        e.st = st; e.ctl = c; e.mr = mr;
        exp_q.push_back(e);
    endfunction

    function automatic int cls_of(logic [5:0] op, logic [5:0] fn, bit subi_en);
        if (op == 6'd0 && fn == 6'b001000) return C_JR;
        if (op == 6'd0) return C_R;
        if (op == 6'd8 || op == 6'd12 || op == 6'd13 || op == 6'd10 || op == 6'd15 || (subi_en && op == 6'd31)) return C_I;
        if (op == 6'd35 || op == 6'd32 || op == 6'd33) return C_LD;
        if (op == 6'd43 || op == 6'd40 || op == 6'd41) return C_ST;
        if (op == 6'd4 || op == 6'd5 || op == 6'd1) return C_BR;
        if (op == 6'd2) return C_J;
        if (op == 6'd3) return C_JAL;
        return C_ILL;
    endfunction

    // Expected cycle trace of one instruction, flags = {irw,pcw,iord,mrd,mwr,m2r,rdst,rwr,asa,jal}
    function automatic void build(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw, bit trap_ill, bit subi_en);
        int cls;
        logic [5:0] bop;
        logic pw;
        cls = cls_of(op, fn, subi_en);
        exp_q.delete();
        for (int i = 0; i < fw; i++) add(4'd1, ctl(10'b0001000000, 2'b01, 2'b00, 6'd0, 1'b0), 1'b0);
        add(4'd1, ctl(10'b1101000000, 2'b01, 2'b00, 6'd0, 1'b0), 1'b1);
        add(4'd2, ctl(10'b0, 2'b11, 2'b00, 6'd0, (cls == C_ILL) && !trap_ill), 1'($urandom));
        case (cls)
            C_R: begin
                add(4'd7, ctl(10'b0000000010, 2'b00, 2'b00, 6'b000010, 1'b0), 1'($urandom));
                add(4'd8, ctl(10'b0000001100, 2'b00, 2'b00, 6'd0, 1'b1), 1'($urandom));
            end
            C_JR: add(4'd14, ctl(10'b0100000000, 2'b00, 2'b11, 6'd0, 1'b1), 1'($urandom));
            C_I: begin
                add(4'd9, ctl(10'b0000000010, 2'b10, 2'b00, op, 1'b0), 1'($urandom));
                add(4'd10, ctl(10'b0000000100, 2'b00, 2'b00, 6'd0, 1'b1), 1'($urandom));
            end
            C_LD: begin
                add(4'd3, ctl(10'b0000000010, 2'b10, 2'b00, 6'd0, 1'b0), 1'($urandom));
                for (int i = 0; i < mw; i++) add(4'd4, ctl(10'b0011000000, 2'b00, 2'b00, 6'd0, 1'b0), 1'b0);
                add(4'd4, ctl(10'b0011000000, 2'b00, 2'b00, 6'd0, 1'b0), 1'b1);
                add(4'd5, ctl(10'b0000010100, 2'b00, 2'b00, 6'd0, 1'b1), 1'($urandom));
            end
            C_ST: begin
                add(4'd3, ctl(10'b0000000010, 2'b10, 2'b00, 6'd0, 1'b0), 1'($urandom));
                for (int i = 0; i < mw; i++) add(4'd6, ctl(10'b0010100000, 2'b00, 2'b00, 6'd0, 1'b0), 1'b0);
                add(4'd6, ctl(10'b0010100000, 2'b00, 2'b00, 6'd0, 1'b1), 1'b1);
            end
            C_BR: begin
                if (op == 6'b000101) begin bop = 6'b000101; pw = ~z; end
                else if (op == 6'b000100) begin bop = 6'b000001; pw = z; end
                else begin bop = 6'b111111; pw = z; end
                add(4'd11, ctl({1'b0, pw, 6'b0, 1'b1, 1'b0}, 2'b00, 2'b01, bop, 1'b1), 1'($urandom));
            end
            C_J:   add(4'd12, ctl(10'b0100000000, 2'b00, 2'b10, 6'd0, 1'b1), 1'($urandom));
            C_JAL: add(4'd13, ctl(10'b0100000101, 2'b00, 2'b10, 6'd0, 1'b1), 1'($urandom));
            default: if (trap_ill) add(4'd15, 21'd0, 1'($urandom));
        endcase
    endfunction

    // Drives one instruction from FETCH and compares every cycle against the expected trace.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw, input string name);
        opcode = op; funct = fn; zero = z;
        build(op, fn, z, fw, mw, A_TRAP, A_SUBI);
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = exp_q[i].mr;
            @(negedge clk);
            n_checks++;
            if (state !== exp_q[i].st) begin
                n_fail++; $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, state, exp_q[i].st);
            end
            n_checks++;
            if (w_obs !== exp_q[i].ctl) begin
                n_fail++; $display("FAIL %s cyc%0d controls: got %b want %b", name, i, w_obs, exp_q[i].ctl);
            end
            n_checks++;
            if (retired_count !== exp_cnt) begin
                n_fail++; $display("FAIL %s cyc%0d retired_count: got %0d want %0d", name, i, retired_count, exp_cnt);
            end
            n_checks++;
            if (illegal !== (exp_q[i].st == 4'd15)) begin
                n_fail++; $display("FAIL %s cyc%0d illegal: got %b want %b", name, i, illegal, exp_q[i].st == 4'd15);
            end
            @(posedge clk); #1;
            if (exp_q[i].ctl[0]) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_b = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || w_obs !== 21'd0 || retired_count !== 32'd0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset: state=%0d ctl=%b cnt=%0d ill=%b want 0", state, w_obs, retired_count, illegal);
        end
        n_checks++;
        if (state_b !== 4'd0 || retired_count_b !== 3'd0 || illegal_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: state=%0d cnt=%0d ill=%b want 0", state_b, retired_count_b, illegal_b);
        end
        @(posedge clk); #1;
        reset = 1'b0; reset_b = 1'b0; exp_cnt = 32'd0;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL idle_to_fetch: state got %0d want 1", state);
        end
    endtask

    task automatic test_rtype();
        test_reset();
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "rtype");
        n_checks++;
        if (retired_count !== 32'd1) begin
            n_fail++; $display("FAIL rtype_count: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        for (int k = 0; k < 9; k++) run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "wrap");
        n_checks++;
        if (retired_count_b !== 3'd1 || state_b !== 4'd1) begin
            n_fail++; $display("FAIL wrap: cnt_b=%0d state_b=%0d want 1,1", retired_count_b, state_b);
        end
    endtask

    task automatic test_subi_disabled();
        run_instr(6'b011111, 6'd0, 1'b0, 1, 0, "subi");
        n_checks++;
        if (state_b !== 4'd15 || illegal_b !== 1'b1 || retired_count_b !== 3'd1) begin
            n_fail++; $display("FAIL subi_trap_b: state=%0d ill=%b cnt=%0d want 15,1,1", state_b, illegal_b, retired_count_b);
        end
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'd0, 1'b0, 0, 3, "lw_wait");
        run_instr(6'b101011, 6'd0, 1'b0, 2, 2, "sw_wait");
    endtask

    task automatic test_branch();
        run_instr(6'b000101, 6'd0, 1'b1, 0, 0, "bne_z1");
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_z1");
        run_instr(6'b000001, 6'd0, 1'b0, 0, 0, "bez_z0");
        run_instr(6'b000101, 6'd0, 1'b0, 0, 0, "bne_z0");
    endtask

    task automatic test_jumps();
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");
        run_instr(6'b000011, 6'd0, 1'b0, 0, 0, "jal");
        run_instr(6'b000010, 6'd0, 1'b0, 1, 0, "j");
    endtask

    task automatic test_random();
        logic [5:0] pool [0:18] = '{6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd10, 6'd15, 6'd31, 6'd35, 6'd32,
                                    6'd33, 6'd43, 6'd40, 6'd41, 6'd4, 6'd5, 6'd1, 6'd2, 6'd3};
        logic [5:0] op, fn;
        for (int k = 0; k < 40; k++) begin
            op = pool[$urandom_range(0, 18)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_trap();
        logic [31:0] held;
        run_instr(6'b111110, 6'd0, 1'b0, 0, 0, "trap_entry");
        held = exp_cnt;
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom); opcode = 6'($urandom);
            @(negedge clk);
            n_checks++;
            if (state !== 4'd15 || illegal !== 1'b1 || retired_count !== held || w_obs !== 21'd0) begin
                n_fail++; $display("FAIL trap_hold cyc%0d: state=%0d ill=%b cnt=%0d ctl=%b want 15,1,%0d,0",
                                   k, state, illegal, retired_count, w_obs, held);
            end
            @(posedge clk); #1;
        end
        test_reset();
    endtask

    task automatic test_reset_midinstr();
        opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd6 || mem_write !== 1'b1) begin
            n_fail++; $display("FAIL memwr_reach: state=%0d mem_write=%b want 6,1", state, mem_write);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_write !== 1'b0 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL async_abort: state=%0d mem_write=%b done=%b want 0,0,0", state, mem_write, instr_done);
        end
        @(posedge clk); #1;
        n_checks++;
        if (instr_done !== 1'b0 || retired_count !== 32'd0) begin
            n_fail++; $display("FAIL abort_no_pulse: done=%b cnt=%0d want 0,0", instr_done, retired_count);
        end
        test_reset();
    endtask

    initial begin
        opcode = 6'd0; funct = 6'd0; exp_cnt = 32'd0;
        test_reset();
        test_wrap();
        test_subi_disabled();
        test_rtype();
        test_lw();
        test_branch();
        test_jumps();
        test_random();
        test_trap();
        test_reset_midinstr();
        test_rtype();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
